// File: rtl/fifo_share_pkg.sv
// Shared defaults and helpers for the shared-FIFO controller.
package fifo_share_pkg;

  localparam int DEF_WIDTH_DATA = 288;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NUM_REQ    = 4;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_share_ctrl_if.sv
// Producer, FIFO-port and consumer signals of the shared-FIFO controller.
// master = the controller, slave = its surroundings (producers, FIFO, consumer).
interface fifo_share_ctrl_if #(
  parameter int WIDTH_DATA = 288,
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH + 1)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*WIDTH_DATA-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          write_en;
  logic [WIDTH_DATA-1:0]         write_dt;
  logic                          read_en;
  logic [WIDTH_DATA-1:0]         read_dt;

  logic                          out_valid;
  logic [WIDTH_DATA-1:0]         out_data;
  logic                          out_ready;

  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_full;
  logic                          fifo_empty;

  modport master (
    input  req_valid, req_data, read_dt, out_ready,
    output req_ready, write_en, write_dt, read_en,
           out_valid, out_data, fifo_count, fifo_full, fifo_empty
  );

  modport slave (
    output req_valid, req_data, read_dt, out_ready,
    input  req_ready, write_en, write_dt, read_en,
           out_valid, out_data, fifo_count, fifo_full, fifo_empty
  );

endinterface

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter
  import fifo_share_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Rotating priority search starting at ptr; nothing granted when disabled.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!gnt_any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = IDX_W'(idx);
          gnt_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one flagless FIFO between NUM_REQ producers and one consumer:
// round-robin write arbitration, occupancy tracking, and a 2-entry output
// buffer that hides the FIFO's one-cycle read latency.
module fifo_share_ctrl
  import fifo_share_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DEPTH      = DEF_DEPTH
) (
  input logic              clk,
  input logic              rst,
  fifo_share_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic                  ob_head_q, ob_head_d;
  logic [WIDTH_DATA-1:0] ob_data_q [2];
  logic [WIDTH_DATA-1:0] ob_data_d [2];

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  can_write;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            ob_fill;

  assign can_write = (count_q < CNT_W'(DEPTH));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .enable  (~rst & can_write),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Buffer occupancy one cycle ahead, counting the read already in flight.
  assign pop     = bus.out_valid & bus.out_ready;
  assign ob_fill = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_en   = ~rst & (count_q != '0) & (ob_fill < 3'd2);

  assign bus.req_ready  = gnt;
  assign bus.write_en   = gnt_any;
  assign bus.write_dt   = gnt_any ? bus.req_data[int'(gnt_idx)*WIDTH_DATA +: WIDTH_DATA]
                                  : '0;
  assign bus.read_en    = rd_en;
  assign bus.out_valid  = (ob_cnt_q != 2'd0);
  assign bus.out_data   = ob_data_q[ob_head_q];
  assign bus.fifo_count = count_q;
  assign bus.fifo_full  = (count_q == CNT_W'(DEPTH));
  assign bus.fifo_empty = (count_q == '0);

  // Next-state for occupancy counter, rr pointer, read pipeline and output buffer.
  always_comb begin
    count_d   = count_q;
    ptr_d     = ptr_q;
    rd_pend_d = rd_en;
    ob_cnt_d  = ob_cnt_q;
    ob_head_d = ob_head_q;
    ob_data_d = ob_data_q;

    if (gnt_any && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!gnt_any && rd_en) begin
      count_d = count_q - CNT_W'(1);
    end

    if (gnt_any) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    // Entry behind the head is the free slot; with an empty buffer that is the head itself.
    if (rd_pend_q) begin
      ob_data_d[ob_head_q ^ ob_cnt_q[0]] = bus.read_dt;
    end
    if (pop) begin
      ob_head_d = ~ob_head_q;
    end
    ob_cnt_d = ob_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  end

  // Control state with synchronous reset; FIFO contents are treated as lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob_head_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_head_q <= ob_head_d;
    end
  end

  // Buffer payload needs no reset; validity is carried by ob_cnt_q.
  always_ff @(posedge clk) begin
    ob_data_q <= ob_data_d;
  end

endmodule
